sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: instruction fetch (IF) and data memory (ME).
- Exactly one transaction is in flight at a time.
- ME has priority; a starvation counter guarantees IF progress.
- Sits between the pipeline stages and the SDRAM controller in the CLOCK_50 domain.

Parameters:
- ADDR_W, 25, word address width (13 row + 2 bank + 10 column).
- DATA_W, 16, SDRAM word width.
- STARVE_LIMIT, 4, consecutive ME grants allowed while IF is pending before IF is forced.
- WDOG_CYCLES, 1024, watchdog timeout in cycles (optional feature only).

Ports:
- CLOCK_50  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held with if_addr until if_ack.
- if_addr  in  ADDR_W  IF read address.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- if_err  out  1  with if_ack: transaction timed out.
- me_req  in  1  ME request; held with payload until me_ack.
- me_we  in  1  1 = write, 0 = read.
- me_addr  in  ADDR_W  ME address.
- me_wdata  in  DATA_W  ME write data.
- me_ack  out  1  one-cycle pulse; done (read data valid).
- me_rdata  out  DATA_W  ME read data.
- me_err  out  1  with me_ack: transaction timed out.
- ctl_valid  out  1  command valid to controller.
- ctl_ready  in  1  controller accepts the command when ctl_valid and ctl_ready are both high.
- ctl_we  out  1  command write enable.
- ctl_addr  out  ADDR_W  command address.
- ctl_wdata  out  DATA_W  command write data.
- ctl_rvalid  in  1  one-cycle completion pulse (read data or write done).
- ctl_rdata  in  DATA_W  read data, valid with ctl_rvalid.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = IF, 1 = ME; latched at grant.

Behaviour:
- All outputs are registered.
- Reset values: all acks, errs and ctl_valid = 0; all data/address outputs = 0; owner = 0; busy = 0; starve counter = 0; watchdog counter = 0; state = IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req → stay.
  - Otherwise grant one requester.
  - Latch owner and payload into ctl_* (IF forces ctl_we = 0, ctl_wdata = 0).
  - Go to ISSUE; ctl_valid = 1 in the next cycle.
- Grant rule:
  - Only me_req → ME. Only if_req → IF.
  - Both requesting, starve counter < STARVE_LIMIT → ME, and the counter increments.
  - Both requesting, starve counter == STARVE_LIMIT → IF.
  - Any IF grant clears the counter.
  - ME grant with if_req low leaves the counter unchanged.
- ISSUE: hold ctl_valid and payload stable until ctl_ready. On the accept cycle drop ctl_valid next cycle and go to WAIT.
- WAIT: ignore ctl_rvalid in any other state. On ctl_rvalid, capture ctl_rdata into the owner's rdata and go to DONE.
- DONE:
  - Owner's ack = 1 for exactly this cycle; the other requester's ack stays 0.
  - Next state is IDLE.
  - rdata holds its value until the next capture by that owner.
- Requester rules:
  - Deassert req in the cycle after its ack.
  - Keep req low for at least one cycle before re-requesting.
  - The arbiter never grants a requester in the cycle after that requester's ack.
- Minimum latency: req seen in IDLE at cycle 0, with ctl_ready and ctl_rvalid immediate → ack at cycle 3.
- Requests arriving during busy wait; they are not lost and are not reordered.
- Writes also end with ack (me_rdata = ctl_rdata captured, don't-care).
- Reset mid-transaction: return to IDLE immediately and drop ctl_valid. No ack is issued for the aborted transaction; requesters must reissue.

Optional Feature:
- Macro: SDRAM_ARB_WATCHDOG_EN.
- Enabled:
  - Counter clears on entry to ISSUE and increments in ISSUE and WAIT.
  - On reaching WDOG_CYCLES: drop ctl_valid, go to DONE, pulse the owner's ack with err = 1 and rdata = 0.
  - A late ctl_rvalid after timeout is ignored (arbiter is not in WAIT).
- Disabled: no counter; the arbiter waits indefinitely; if_err and me_err are tied to 0.

Test Plan:
- IF-only read: if_addr = 0x0000123, ctl_ready = 1 at once, ctl_rvalid with 0xBEEF two cycles after accept → ctl_addr = 0x0000123, ctl_we = 0, single if_ack with if_rdata = 0xBEEF, me_ack never high.
- ME write: me_we = 1, me_addr = 0x1FFFFFF, me_wdata = 0xA5A5, ctl_ready delayed 5 cycles → ctl_valid and payload stable for all 6 cycles, one me_ack after rvalid.
- Simultaneous requests held continuously, STARVE_LIMIT = 4 → grant order ME, ME, ME, ME, IF, ME, ME, ME, ME, IF.
- Back-to-back: if_req raised while ME is in WAIT → IF granted in the first IDLE after ME's DONE; no cycle with both acks high.
- Reset asserted in WAIT → next cycle state IDLE, ctl_valid = 0, no ack; a later ctl_rvalid pulse is ignored.
- (SDRAM_ARB_WATCHDOG_EN, WDOG_CYCLES = 16) ctl_ready never asserted → me_ack and me_err = 1 exactly 16 cycles after ISSUE entry, me_rdata = 0, arbiter back in IDLE.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between the
// instruction-fetch (IF) and data-memory (ME) requesters, one transaction
// in flight at a time. ME has priority; a starvation counter forces an IF
// grant after STARVE_LIMIT consecutive contested ME grants.
// Optional watchdog: define SDRAM_ARB_WATCHDOG_EN to time out transactions
// after WDOG_CYCLES cycles in ISSUE/WAIT (ack with err = 1, rdata = 0).
module sdram_arbiter #(
   parameter int ADDR_W       = 25,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4,
   parameter int WDOG_CYCLES  = 1024
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   // instruction fetch requester
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   // data memory requester
   input  logic              me_req,
   input  logic              me_we,
   input  logic [ADDR_W-1:0] me_addr,
   input  logic [DATA_W-1:0] me_wdata,
   output logic              me_ack,
   output logic [DATA_W-1:0] me_rdata,
   output logic              me_err,
   // SDRAM controller command port
   output logic              ctl_valid,
   input  logic              ctl_ready,
   output logic              ctl_we,
   output logic [ADDR_W-1:0] ctl_addr,
   output logic [DATA_W-1:0] ctl_wdata,
   input  logic              ctl_rvalid,
   input  logic [DATA_W-1:0] ctl_rdata,
   // status
   output logic              busy,
   output logic              owner
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   starve_cnt;
   logic            grant_me, grant_if;
   logic            accept, capture, abort;
   logic            timeout;

`ifdef SDRAM_ARB_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   // watchdog: restarts with each grant, counts every cycle in ISSUE/WAIT
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         wdog_cnt <= '0;
      else if (grant_me || grant_if)
         wdog_cnt <= '0;
      else if (state == ISSUE || state == WAIT)
         wdog_cnt <= wdog_cnt + 1'b1;
   end

   // fires in the last allowed cycle so the ack lands WDOG_CYCLES after ISSUE entry
   assign timeout = (state == ISSUE || state == WAIT) &&
                    (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
   logic [31:0] wdog_unused;
   assign wdog_unused = WDOG_CYCLES;
   assign timeout     = 1'b0;
`endif

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state plus the one-cycle event strobes that drive the output registers
   always_comb begin
      state_nxt = state;
      grant_me  = 1'b0;
      grant_if  = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            // ME wins unless IF is also waiting and has been passed over enough times
            if (me_req && (!if_req || starve_cnt < SW'(STARVE_LIMIT)))
               grant_me = 1'b1;
            else if (if_req)
               grant_if = 1'b1;
            if (grant_me || grant_if)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            if (timeout) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end else if (ctl_ready) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // a completion arriving on the timeout cycle is still taken as real data
            if (ctl_rvalid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (timeout) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // starvation counter: counts contested ME grants, any IF grant clears it
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         starve_cnt <= '0;
      else if (grant_if)
         starve_cnt <= '0;
      else if (grant_me && if_req)
         starve_cnt <= starve_cnt + 1'b1;
   end

   // registered outputs: command latch at grant, acks/rdata at completion
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         if_rdata  <= '0;
         me_ack    <= 1'b0;
         me_err    <= 1'b0;
         me_rdata  <= '0;
         ctl_valid <= 1'b0;
         ctl_we    <= 1'b0;
         ctl_addr  <= '0;
         ctl_wdata <= '0;
         busy      <= 1'b0;
         owner     <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         if_err <= 1'b0;
         me_ack <= 1'b0;
         me_err <= 1'b0;
         busy   <= (state_nxt != IDLE);
         if (grant_me || grant_if) begin
            owner     <= grant_me;
            ctl_valid <= 1'b1;
            ctl_we    <= grant_me & me_we;
            ctl_addr  <= grant_me ? me_addr : if_addr;
            ctl_wdata <= grant_me ? me_wdata : '0;
         end
         if (accept || abort)
            ctl_valid <= 1'b0;
         if (capture || abort) begin
            if (owner) begin
               me_ack   <= 1'b1;
               me_err   <= abort;
               me_rdata <= abort ? '0 : ctl_rdata;
            end else begin
               if_ack   <= 1'b1;
               if_err   <= abort;
               if_rdata <= abort ? '0 : ctl_rdata;
            end
         end
      end
   end

endmodule
